// File: rtl/pong_pkg.sv
// Shared encodings, widths and helpers for the Pong match controller.
package pong_pkg;

    localparam logic [1:0] MENU  = 2'd0;
    localparam logic [1:0] SERVE = 2'd1;
    localparam logic [1:0] PLAY  = 2'd2;
    localparam logic [1:0] OVER  = 2'd3;

    localparam int SCORE_W   = 4;
    localparam int SCORE_CAP = 15;
    localparam int CLK_HZ    = 25_175_000;

    typedef enum logic [1:0] {
        ST_MENU  = MENU,
        ST_SERVE = SERVE,
        ST_PLAY  = PLAY,
        ST_OVER  = OVER
    } state_t;

    typedef logic [SCORE_W-1:0] score_t;

    // Scores stop at the cap instead of wrapping back to zero.
    function automatic score_t score_inc(input score_t s);
        return (s == score_t'(SCORE_CAP)) ? s : s + score_t'(1);
    endfunction

endpackage

// File: rtl/pong_match_ctrl_if.sv
// Control bundle between the match sequencer (slave side) and the ball/paddle datapath
// plus input logic (master side).
interface pong_match_ctrl_if;
    import pong_pkg::*;

    logic               start_trigger;
    logic [1:0]         mode_choice;
    logic               miss_left;
    logic               miss_right;
    logic               game_startup;
    logic               game_over;
    logic               ball_run;
    logic               round_reset;
    logic               serve_dir;
    logic [1:0]         mode_latched;
    logic [SCORE_W-1:0] score_p1;
    logic [SCORE_W-1:0] score_p2;
    logic               winner;

    modport master (
        output start_trigger, mode_choice, miss_left, miss_right,
        input  game_startup, game_over, ball_run, round_reset, serve_dir,
               mode_latched, score_p1, score_p2, winner
    );

    modport slave (
        input  start_trigger, mode_choice, miss_left, miss_right,
        output game_startup, game_over, ball_run, round_reset, serve_dir,
               mode_latched, score_p1, score_p2, winner
    );

endinterface

// File: rtl/pong_delay_timer.sv
// Up-counter with synchronous clear and a sticky done flag raised on the edge the count
// reaches the terminal value; the count then holds until cleared.
module pong_delay_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic [W-1:0] terminal,
    output logic         done
);

    logic [W-1:0] count_reg;
    logic [W-1:0] count_plus;

    assign count_plus = count_reg + W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
            done      <= 1'b0;
        end else if (clear) begin
            count_reg <= '0;
            done      <= 1'b0;
        end else if (!done) begin
            count_reg <= count_plus;
            done      <= (count_plus == terminal);
        end
    end

endmodule

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: MENU -> SERVE -> PLAY -> OVER flow, scores and winner.
// Optional macro PONG_WIN_BY_TWO_EN enables the win-by-two (deuce) rule.
module pong_match_ctrl
    import pong_pkg::*;
#(
    parameter int MENU_GUARD  = 2_500_000,
    parameter int SERVE_DELAY = 50_350_000,
    parameter int MAX_SCORE   = 11
) (
    input  logic              clk_0,
    input  logic              rst,
    pong_match_ctrl_if.slave  bus
);

    localparam int CNT_MAX = (MENU_GUARD > SERVE_DELAY) ? MENU_GUARD : SERVE_DELAY;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] GUARD_TERM = CNT_W'(MENU_GUARD);
    localparam logic [CNT_W-1:0] SERVE_TERM = CNT_W'(SERVE_DELAY);
    localparam score_t MAX_S = score_t'(MAX_SCORE);

    state_t     state_reg, state_next;
    score_t     score_p1_reg, score_p1_next;
    score_t     score_p2_reg, score_p2_next;
    logic       serve_dir_reg, serve_dir_next;
    logic [1:0] mode_reg, mode_next;
    logic       winner_reg, winner_next;
    logic       armed_reg, armed_next;
    logic       round_reset_reg, round_reset_next;
    logic       ball_run_reg, ball_run_next;
    logic       game_startup_reg, game_startup_next;
    logic       game_over_reg, game_over_next;

    logic             timer_clear;
    logic             timer_done;
    logic [CNT_W-1:0] timer_term;

    score_t p1_inc, p2_inc;
    logic   p1_win, p2_win;

    // One timer serves both the menu guard and the serve delay; every state change restarts it.
    assign timer_term  = (state_reg == ST_MENU) ? GUARD_TERM : SERVE_TERM;
    assign timer_clear = (state_next != state_reg);

    pong_delay_timer #(.W(CNT_W)) u_timer (
        .clk      (clk_0),
        .rst      (rst),
        .clear    (timer_clear),
        .terminal (timer_term),
        .done     (timer_done)
    );

    assign p1_inc = score_inc(score_p1_reg);
    assign p2_inc = score_inc(score_p2_reg);

`ifdef PONG_WIN_BY_TWO_EN
    logic [SCORE_W:0] p1_plus2, p2_plus2;
    assign p1_plus2 = {1'b0, score_p1_reg} + (SCORE_W+1)'(2);
    assign p2_plus2 = {1'b0, score_p2_reg} + (SCORE_W+1)'(2);
    // Lead of two required past the target; reaching the cap ends the match regardless.
    assign p1_win = ((p1_inc >= MAX_S) && ({1'b0, p1_inc} >= p2_plus2))
                    || (p1_inc == score_t'(SCORE_CAP));
    assign p2_win = ((p2_inc >= MAX_S) && ({1'b0, p2_inc} >= p1_plus2))
                    || (p2_inc == score_t'(SCORE_CAP));
`else
    assign p1_win = (p1_inc == MAX_S);
    assign p2_win = (p2_inc == MAX_S);
`endif

    always_comb begin
        state_next       = state_reg;
        score_p1_next    = score_p1_reg;
        score_p2_next    = score_p2_reg;
        serve_dir_next   = serve_dir_reg;
        mode_next        = mode_reg;
        winner_next      = winner_reg;
        armed_next       = armed_reg;
        round_reset_next = 1'b0;

        case (state_reg)
            ST_MENU: begin
                if (timer_done && bus.start_trigger && (bus.mode_choice != 2'd0)) begin
                    state_next       = ST_SERVE;
                    mode_next        = bus.mode_choice;
                    score_p1_next    = '0;
                    score_p2_next    = '0;
                    serve_dir_next   = 1'b0;
                    round_reset_next = 1'b1;
                end
            end
            ST_SERVE: begin
                if (timer_done) begin
                    state_next = ST_PLAY;
                end
            end
            ST_PLAY: begin
                // A right-wall miss takes priority when both walls report in one cycle.
                if (bus.miss_right) begin
                    score_p1_next  = p1_inc;
                    serve_dir_next = 1'b1;
                    if (p1_win) begin
                        state_next  = ST_OVER;
                        winner_next = 1'b0;
                        armed_next  = 1'b0;
                    end else begin
                        state_next       = ST_SERVE;
                        round_reset_next = 1'b1;
                    end
                end else if (bus.miss_left) begin
                    score_p2_next  = p2_inc;
                    serve_dir_next = 1'b0;
                    if (p2_win) begin
                        state_next  = ST_OVER;
                        winner_next = 1'b1;
                        armed_next  = 1'b0;
                    end else begin
                        state_next       = ST_SERVE;
                        round_reset_next = 1'b1;
                    end
                end
            end
            ST_OVER: begin
                // The key must be released once before a press can leave the result screen.
                if (!bus.start_trigger) begin
                    armed_next = 1'b1;
                end else if (armed_reg) begin
                    state_next = ST_MENU;
                    armed_next = 1'b0;
                end
            end
            default: state_next = ST_MENU;
        endcase

        game_startup_next = (state_next == ST_MENU);
        game_over_next    = (state_next == ST_OVER);
        ball_run_next     = (state_next == ST_PLAY);
    end

    always_ff @(posedge clk_0 or posedge rst) begin
        if (rst) begin
            state_reg        <= ST_MENU;
            score_p1_reg     <= '0;
            score_p2_reg     <= '0;
            serve_dir_reg    <= 1'b0;
            mode_reg         <= 2'd0;
            winner_reg       <= 1'b0;
            armed_reg        <= 1'b0;
            round_reset_reg  <= 1'b0;
            ball_run_reg     <= 1'b0;
            game_startup_reg <= 1'b1;
            game_over_reg    <= 1'b0;
        end else begin
            state_reg        <= state_next;
            score_p1_reg     <= score_p1_next;
            score_p2_reg     <= score_p2_next;
            serve_dir_reg    <= serve_dir_next;
            mode_reg         <= mode_next;
            winner_reg       <= winner_next;
            armed_reg        <= armed_next;
            round_reset_reg  <= round_reset_next;
            ball_run_reg     <= ball_run_next;
            game_startup_reg <= game_startup_next;
            game_over_reg    <= game_over_next;
        end
    end

    assign bus.game_startup = game_startup_reg;
    assign bus.game_over    = game_over_reg;
    assign bus.ball_run     = ball_run_reg;
    assign bus.round_reset  = round_reset_reg;
    assign bus.serve_dir    = serve_dir_reg;
    assign bus.mode_latched = mode_reg;
    assign bus.score_p1     = score_p1_reg;
    assign bus.score_p2     = score_p2_reg;
    assign bus.winner       = winner_reg;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Scenario bench for pong_match_ctrl with a point-by-point scoreboard of expected scores.
module tb_pong_match_ctrl;

    localparam int MG = 4;
    localparam int SD = 8;
    localparam int MS = 3;

    logic clk_0 = 1'b0;
    logic rst   = 1'b1;
    always #5 clk_0 = ~clk_0;

    pong_match_ctrl_if bus();

    pong_match_ctrl #(.MENU_GUARD(MG), .SERVE_DELAY(SD), .MAX_SCORE(MS)) dut (
        .clk_0 (clk_0),
        .rst   (rst),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [3:0] p1;
        logic [3:0] p2;
        logic       dir;
        logic       over;
        logic       winner;
        logic [1:0] mode;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   m_p1 = 0;
    int   m_p2 = 0;
    logic [1:0] m_mode = 2'd0;

    function automatic bit model_win(input int s, input int o);
`ifdef PONG_WIN_BY_TWO_EN
        return ((s >= MS) && (s >= o + 2)) || (s == 15);
`else
        return (s == MS);
`endif
    endfunction

    task automatic tick;
        @(posedge clk_0);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.start_trigger = 1'b0;
        bus.mode_choice   = 2'd0;
        bus.miss_left     = 1'b0;
        bus.miss_right    = 1'b0;
        tick();
        tick();
        checks++; if (bus.game_startup !== 1'b1) begin errors++; $display("FAIL rst_startup got %b want 1", bus.game_startup); end
        checks++; if (bus.game_over !== 1'b0) begin errors++; $display("FAIL rst_over got %b want 0", bus.game_over); end
        checks++; if (bus.ball_run !== 1'b0) begin errors++; $display("FAIL rst_ball_run got %b want 0", bus.ball_run); end
        checks++; if (bus.round_reset !== 1'b0) begin errors++; $display("FAIL rst_round_reset got %b want 0", bus.round_reset); end
        checks++; if (bus.score_p1 !== 4'd0 || bus.score_p2 !== 4'd0) begin errors++; $display("FAIL rst_scores got %0d/%0d want 0/0", bus.score_p1, bus.score_p2); end
        checks++; if (bus.mode_latched !== 2'd0) begin errors++; $display("FAIL rst_mode got %0d want 0", bus.mode_latched); end
        checks++; if (bus.winner !== 1'b0 || bus.serve_dir !== 1'b0) begin errors++; $display("FAIL rst_winner_dir got %b/%b want 0/0", bus.winner, bus.serve_dir); end
        rst = 1'b0;
        $display("reset released");
    endtask

    // Holds start with the given mode from now on; expects round_reset after exactly exp_edges edges.
    task automatic start_match(input logic [1:0] mode, input int exp_edges);
        int   n;
        exp_t e;
        bus.start_trigger = 1'b1;
        bus.mode_choice   = mode;
        m_p1 = 0; m_p2 = 0; m_mode = mode;
        sb.push_back('{p1: 4'd0, p2: 4'd0, dir: 1'b0, over: 1'b0, winner: 1'b0, mode: mode});
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.round_reset !== 1'b1 && n < 20);
        checks++;
        if (n != exp_edges) begin errors++; $display("FAIL start_latency got %0d edges want %0d", n, exp_edges); end
        e = sb.pop_front();
        checks++;
        if (bus.round_reset !== 1'b1 || bus.mode_latched !== e.mode || bus.score_p1 !== e.p1 ||
            bus.score_p2 !== e.p2 || bus.serve_dir !== e.dir || bus.game_startup !== 1'b0) begin
            errors++;
            $display("FAIL start_state got rr=%b mode=%0d %0d/%0d dir=%b menu=%b want rr=1 mode=%0d 0/0 dir=0 menu=0",
                     bus.round_reset, bus.mode_latched, bus.score_p1, bus.score_p2, bus.serve_dir,
                     bus.game_startup, e.mode);
        end
        bus.start_trigger = 1'b0;
        $display("match start mode=%0d after %0d edges", mode, n);
    endtask

    task automatic serve_wait;
        for (int i = 1; i <= SD; i++) begin
            tick();
            checks++;
            if (bus.ball_run !== 1'b0 || bus.round_reset !== 1'b0) begin
                errors++; $display("FAIL serve_hold edge %0d got run=%b rr=%b want 0/0", i, bus.ball_run, bus.round_reset);
            end
        end
        tick();
        checks++;
        if (bus.ball_run !== 1'b1) begin errors++; $display("FAIL serve_release got %b want 1", bus.ball_run); end
    endtask

    task automatic play_point(input bit right, input bit left, output bit over);
        exp_t e;
        logic dir;
        logic win;
        bus.miss_right = right;
        bus.miss_left  = left;
        win = 1'b0;
        if (right) begin
            m_p1 = (m_p1 < 15) ? m_p1 + 1 : 15; dir = 1'b1; over = model_win(m_p1, m_p2); win = 1'b0;
        end else begin
            m_p2 = (m_p2 < 15) ? m_p2 + 1 : 15; dir = 1'b0; over = model_win(m_p2, m_p1); win = 1'b1;
        end
        sb.push_back('{p1: 4'(m_p1), p2: 4'(m_p2), dir: dir, over: over, winner: win, mode: m_mode});
        tick();
        bus.miss_right = 1'b0;
        bus.miss_left  = 1'b0;
        checks++;
        if (bus.round_reset !== 1'b1 && bus.game_over !== 1'b1) begin
            errors++; $display("FAIL point_event got rr=%b over=%b want one of them", bus.round_reset, bus.game_over);
            void'(sb.pop_front());
        end else begin
            e = sb.pop_front();
            checks++;
            if (bus.score_p1 !== e.p1 || bus.score_p2 !== e.p2 || bus.serve_dir !== e.dir ||
                bus.game_over !== e.over || bus.round_reset !== !e.over || bus.ball_run !== 1'b0 ||
                (e.over && bus.winner !== e.winner)) begin
                errors++;
                $display("FAIL point_state got %0d/%0d dir=%b over=%b rr=%b run=%b win=%b want %0d/%0d dir=%b over=%b rr=%b run=0 win=%b",
                         bus.score_p1, bus.score_p2, bus.serve_dir, bus.game_over, bus.round_reset,
                         bus.ball_run, bus.winner, e.p1, e.p2, e.dir, e.over, !e.over, e.winner);
            end
        end
        $display("point R=%b L=%b -> model %0d/%0d over=%b dut %0d/%0d", right, left, m_p1, m_p2, over,
                 bus.score_p1, bus.score_p2);
        if (!over) serve_wait();
    endtask

    task automatic test_guard;
        tick();                 // edge 1: trigger is raised after it, so edges 2..4 fall in the guard
        start_match(2'd1, 4);
    endtask

    task automatic test_serve_timing;
        for (int i = 1; i <= SD; i++) begin
            tick();
            checks++;
            if (bus.ball_run !== 1'b0) begin errors++; $display("FAIL serve_timing edge %0d got %b want 0", i, bus.ball_run); end
            bus.miss_right = (i == 2);
            bus.miss_left  = (i == 5);
        end
        bus.miss_right = 1'b0;
        bus.miss_left  = 1'b0;
        tick();
        checks++;
        if (bus.ball_run !== 1'b1) begin errors++; $display("FAIL serve_timing_rise got %b want 1", bus.ball_run); end
        checks++;
        if (bus.score_p1 !== 4'd0 || bus.score_p2 !== 4'd0) begin
            errors++; $display("FAIL serve_miss_ignored got %0d/%0d want 0/0", bus.score_p1, bus.score_p2);
        end
        $display("serve timing done");
    endtask

    task automatic test_scoring;
        bit over;
        play_point(1'b1, 1'b0, over);
        play_point(1'b1, 1'b1, over);
    endtask

    task automatic test_game_over;
        bit over;
        int n;
        over = 1'b0;
        n = 0;
        bus.start_trigger = 1'b1;
        while (!over && n < 20) begin
            play_point(1'b0, 1'b1, over);
            n++;
        end
        checks++;
        if (bus.game_over !== 1'b1 || bus.winner !== 1'b1) begin
            errors++; $display("FAIL over_p2 got over=%b win=%b want 1/1", bus.game_over, bus.winner);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.game_over !== 1'b1 || bus.score_p1 !== 4'(m_p1) || bus.score_p2 !== 4'(m_p2)) begin
                errors++; $display("FAIL over_hold got over=%b %0d/%0d want 1 %0d/%0d",
                                   bus.game_over, bus.score_p1, bus.score_p2, m_p1, m_p2);
            end
        end
        bus.start_trigger = 1'b0;
        tick();
        checks++;
        if (bus.game_over !== 1'b1) begin errors++; $display("FAIL over_arm got %b want 1", bus.game_over); end
        bus.start_trigger = 1'b1;
        bus.mode_choice   = 2'd1;
        tick();
        checks++;
        if (bus.game_startup !== 1'b1 || bus.game_over !== 1'b0) begin
            errors++; $display("FAIL over_exit got menu=%b over=%b want 1/0", bus.game_startup, bus.game_over);
        end
        $display("game over left to menu");
        start_match(2'd1, MG + 1);
        serve_wait();
    endtask

    task automatic test_async_reset;
        bit over;
        play_point(1'b1, 1'b0, over);
        play_point(1'b1, 1'b0, over);
        play_point(1'b0, 1'b1, over);
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.game_startup !== 1'b1 || bus.ball_run !== 1'b0) begin
            errors++; $display("FAIL async_rst_state got menu=%b run=%b want 1/0", bus.game_startup, bus.ball_run);
        end
        checks++;
        if (bus.score_p1 !== 4'd0 || bus.score_p2 !== 4'd0) begin
            errors++; $display("FAIL async_rst_scores got %0d/%0d want 0/0", bus.score_p1, bus.score_p2);
        end
        tick();
        rst = 1'b0;
        $display("async reset mid-play");
    endtask

    task automatic test_mode_zero;
        bus.start_trigger = 1'b1;
        bus.mode_choice   = 2'd0;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (bus.game_startup !== 1'b1 || bus.round_reset !== 1'b0) begin
                errors++; $display("FAIL mode_zero got menu=%b rr=%b want 1/0", bus.game_startup, bus.round_reset);
            end
        end
        start_match(2'd2, 1);
        serve_wait();
    endtask

    task automatic test_alternating;
        bit over;
        int n;
        over = 1'b0;
        n = 0;
        while (!over && n < 40) begin
            play_point(n[0] == 1'b0, n[0] == 1'b1, over);
            n++;
        end
`ifdef PONG_WIN_BY_TWO_EN
        checks++;
        if (bus.score_p1 !== 4'd15 || bus.score_p2 !== 4'd14 || bus.game_over !== 1'b1 || bus.winner !== 1'b0) begin
            errors++; $display("FAIL alt_final got %0d/%0d over=%b win=%b want 15/14 1 0",
                               bus.score_p1, bus.score_p2, bus.game_over, bus.winner);
        end
`else
        checks++;
        if (bus.score_p1 !== 4'd3 || bus.score_p2 !== 4'd2 || bus.game_over !== 1'b1 || bus.winner !== 1'b0) begin
            errors++; $display("FAIL alt_final got %0d/%0d over=%b win=%b want 3/2 1 0",
                               bus.score_p1, bus.score_p2, bus.game_over, bus.winner);
        end
`endif
    endtask

`ifdef PONG_WIN_BY_TWO_EN
    task automatic test_deuce;
        bit over;
        bit seq_r [8] = '{1, 0, 1, 0, 1, 0, 1, 1};
        bus.start_trigger = 1'b0;
        tick();
        bus.start_trigger = 1'b1;
        tick();
        start_match(2'd1, MG + 1);
        serve_wait();
        for (int i = 0; i < 8; i++) begin
            play_point(seq_r[i], !seq_r[i], over);
        end
        checks++;
        if (bus.score_p1 !== 4'd5 || bus.score_p2 !== 4'd3 || bus.game_over !== 1'b1 || bus.winner !== 1'b0) begin
            errors++; $display("FAIL deuce_final got %0d/%0d over=%b win=%b want 5/3 1 0",
                               bus.score_p1, bus.score_p2, bus.game_over, bus.winner);
        end
    endtask
`endif

    initial begin
        bus.start_trigger = 1'b0;
        bus.mode_choice   = 2'd0;
        bus.miss_left     = 1'b0;
        bus.miss_right    = 1'b0;
        test_reset();
        test_guard();
        test_serve_timing();
        test_scoring();
        test_game_over();
        test_async_reset();
        test_mode_zero();
        test_alternating();
`ifdef PONG_WIN_BY_TWO_EN
        test_deuce();
`endif
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL sb_drain got %0d left want 0", sb.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
